// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the multi-cycle MIPS core.
// Holds the PC and fetches one word at a time from instruction memory over a
// req/ack handshake. It presents the latched instruction to decode until the
// datapath retires it, and then computes the next PC from the control-decoder
// outputs, the ALU zero flag, the immediate and rs (for jr).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [31:0]      imem_rdata_i,
  output logic [31:0]      instr_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic             instr_valid_o,
  input  logic             retire_i,
  input  logic             Branch_i,
  input  logic             BranchNe_i,
  input  logic             Jump_i,
  input  logic             Jr_i,
  input  logic             zero_i,
  input  logic [31:0]      imm_ext_i,
  input  logic [31:0]      rs_data_i,
  output logic             fetch_err_o,
  output logic [CNT_W-1:0] retired_cnt_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc_plus4_q, pc_plus4_d;
  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             req_q, req_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0]      next_pc;
  logic             taken;
  logic             jr_misaligned;

  // Next-PC selection: Jr > Jump > taken branch > sequential. Branch inputs are
  // only looked at when neither Jr nor Jump is set, so X on them cannot reach pc.
  always_comb begin
    next_pc = pc_plus4_q;
    taken   = 1'b0;
    if (Jr_i) begin
      next_pc = rs_data_i;
    end else if (Jump_i) begin
      next_pc = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};
    end else begin
      taken = (Branch_i & zero_i) | (BranchNe_i & ~zero_i);
      if (taken) begin
        next_pc = pc_plus4_q + (imm_ext_i << 2);
      end else begin
        next_pc = pc_plus4_q;
      end
    end
  end

  assign jr_misaligned = Jr_i & (rs_data_i[1:0] != 2'b00);

  // FSM next-state and registered-output next values; everything holds by default.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    req_d      = req_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_FETCH: begin
        // Request becomes visible in WAIT, one cycle after entering FETCH.
        req_d   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_ack_i) begin
          instr_d = imem_rdata_i;
          req_d   = 1'b0;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end else begin
          req_d   = 1'b1;
        end
      end
      S_HOLD: begin
        if (retire_i) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (jr_misaligned) begin
            // Bad jr target: keep pc for debug and stop fetching for good.
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d       = next_pc;
            pc_plus4_d = next_pc + 32'd4;
            state_d    = S_FETCH;
          end
        end else begin
          valid_d = 1'b1;
        end
      end
      S_HALT: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
      default: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        state_d = S_HALT;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC + 32'd4;
      instr_q    <= 32'd0;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4_q;
  assign instr_valid_o = valid_q;
  assign fetch_err_o   = err_q;
  assign retired_cnt_o = cnt_q;

endmodule
